tcam_lookup_client: RTL and testbench

Initiator-side controller for the blueswitch TCAM wrapper. It accepts tagged lookup requests over a valid/ready stream and drives the TCAM compare port. It returns hit/address/tag results in request order through a credit-protected result FIFO. It serialises configuration writes into the TCAM write port, draining in-flight lookups first so that no result is taken from a table under update.

---
 rtl/tcam_lookup_client.sv | 156 +++++++++++++++
 tb/tb_tcam_lookup_client.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_lookup_client.sv
// Initiator-side TCAM controller: in-order tagged lookups through a credit-protected
// result FIFO, with configuration writes serialised behind a drain of in-flight lookups.
module tcam_lookup_client #(
  parameter int TCAM_ADDR_WIDTH = 4,
  parameter int TCAM_DATA_WIDTH = 32,
  parameter int TAG_WIDTH       = 8,
  parameter int LOOKUP_LATENCY  = 2,
  parameter int RES_FIFO_DEPTH  = 4,
  parameter int WR_SETTLE       = 2
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       REQ_VALID,
  output logic                       REQ_READY,
  input  logic [TCAM_DATA_WIDTH-1:0] REQ_KEY,
  input  logic [TCAM_DATA_WIDTH-1:0] REQ_MASK,
  input  logic [TAG_WIDTH-1:0]       REQ_TAG,
  output logic                       RES_VALID,
  input  logic                       RES_READY,
  output logic                       RES_HIT,
  output logic [TCAM_ADDR_WIDTH-1:0] RES_ADDR,
  output logic [TAG_WIDTH-1:0]       RES_TAG,
  input  logic                       CFG_WR_REQ,
  input  logic [TCAM_ADDR_WIDTH-1:0] CFG_WR_ADDR,
  input  logic [TCAM_DATA_WIDTH-1:0] CFG_WR_DATA,
  input  logic [TCAM_DATA_WIDTH-1:0] CFG_WR_MASK,
  output logic                       CFG_WR_ACK,
  output logic                       TCAM_WR,
  output logic [TCAM_ADDR_WIDTH-1:0] TCAM_ADDR_WR,
  output logic [TCAM_DATA_WIDTH-1:0] TCAM_DIN,
  output logic [TCAM_DATA_WIDTH-1:0] TCAM_DIN_MASK,
  input  logic                       TCAM_BUSY,
  output logic [TCAM_DATA_WIDTH-1:0] TCAM_CAM_DIN,
  output logic [TCAM_DATA_WIDTH-1:0] TCAM_CAM_DATA_MASK,
  input  logic                       TCAM_MATCH,
  input  logic [TCAM_ADDR_WIDTH-1:0] TCAM_MATCH_ADDR
);
  localparam int CW = $clog2(RES_FIFO_DEPTH + 1);
  localparam int PW = $clog2(RES_FIFO_DEPTH);
  localparam int SW = $clog2(WR_SETTLE + 1);

  typedef enum logic [1:0] {LOOKUP, DRAIN, WRITE, SETTLE} state_t;

  state_t                     state;
  logic [CW-1:0]              credit;
  logic [LOOKUP_LATENCY-1:0]  pipe_v;
  logic [TAG_WIDTH-1:0]       pipe_tag [LOOKUP_LATENCY];
  logic [SW-1:0]              settle_cnt;
  logic                       fifo_hit  [RES_FIFO_DEPTH];
  logic [TCAM_ADDR_WIDTH-1:0] fifo_addr [RES_FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]       fifo_tag  [RES_FIFO_DEPTH];
  logic [PW:0]                wr_ptr, rd_ptr;
  logic                       accept, pop, push;

  assign REQ_READY = RSTN && (state == LOOKUP) && !CFG_WR_REQ && (credit != '0);
  assign accept    = REQ_VALID & REQ_READY;
  assign RES_VALID = (wr_ptr != rd_ptr);
  assign pop       = RES_VALID & RES_READY;
  assign push      = pipe_v[LOOKUP_LATENCY-1];

  // Outputs read as zero whenever the FIFO is empty, including straight out of reset.
  assign RES_HIT  = RES_VALID & fifo_hit[rd_ptr[PW-1:0]];
  assign RES_ADDR = RES_VALID ? fifo_addr[rd_ptr[PW-1:0]] : '0;
  assign RES_TAG  = RES_VALID ? fifo_tag[rd_ptr[PW-1:0]]  : '0;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= accept;
      for (int i = 1; i < LOOKUP_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) pipe_tag[0] <= REQ_TAG;
    for (int i = 1; i < LOOKUP_LATENCY; i++) pipe_tag[i] <= pipe_tag[i-1];
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_hit[wr_ptr[PW-1:0]]  <= TCAM_MATCH;
      fifo_addr[wr_ptr[PW-1:0]] <= TCAM_MATCH ? TCAM_MATCH_ADDR : '0;
      fifo_tag[wr_ptr[PW-1:0]]  <= pipe_tag[LOOKUP_LATENCY-1];
    end
  end

  // Credit spans in-flight plus stored results, so a push always finds a free slot.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      credit <= CW'(RES_FIFO_DEPTH);
    end else if (accept && !pop) begin
      credit <= credit - 1'b1;
    end else if (pop && !accept) begin
      credit <= credit + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state              <= LOOKUP;
      settle_cnt         <= '0;
      CFG_WR_ACK         <= 1'b0;
      TCAM_WR            <= 1'b0;
      TCAM_ADDR_WR       <= '0;
      TCAM_DIN           <= '0;
      TCAM_DIN_MASK      <= '0;
      TCAM_CAM_DIN       <= '0;
      TCAM_CAM_DATA_MASK <= '0;
    end else begin
      CFG_WR_ACK <= 1'b0;
      TCAM_WR    <= 1'b0;
      if (accept) begin
        TCAM_CAM_DIN       <= REQ_KEY;
        TCAM_CAM_DATA_MASK <= REQ_MASK;
      end
      case (state)
        // The requester drops CFG_WR_REQ in the ACK cycle; do not re-arm on it.
        LOOKUP: if (CFG_WR_REQ && !CFG_WR_ACK) state <= DRAIN;
        DRAIN: begin
          if (pipe_v == '0) begin
            state         <= WRITE;
            TCAM_WR       <= 1'b1;
            TCAM_ADDR_WR  <= CFG_WR_ADDR;
            TCAM_DIN      <= CFG_WR_DATA;
            TCAM_DIN_MASK <= CFG_WR_MASK;
          end
        end
        WRITE: begin
          state      <= SETTLE;
          settle_cnt <= SW'(WR_SETTLE - 1);
        end
        SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
          end else if (!TCAM_BUSY) begin
            CFG_WR_ACK <= 1'b1;
            state      <= LOOKUP;
          end
        end
        default: state <= LOOKUP;
      endcase
    end
  end

endmodule

// File: tb/tb_tcam_lookup_client.sv
// Bench for tcam_lookup_client: behavioural TCAM with one-stage match register,
// scoreboard of expected results in accept order.
module tb_tcam_lookup_client;
  logic        CLK = 1'b0;
  logic        RSTN;
  logic        REQ_VALID, REQ_READY;
  logic [31:0] REQ_KEY, REQ_MASK;
  logic [7:0]  REQ_TAG;
  logic        RES_VALID, RES_READY, RES_HIT;
  logic [3:0]  RES_ADDR;
  logic [7:0]  RES_TAG;
  logic        CFG_WR_REQ, CFG_WR_ACK;
  logic [3:0]  CFG_WR_ADDR;
  logic [31:0] CFG_WR_DATA, CFG_WR_MASK;
  logic        TCAM_WR, TCAM_BUSY, TCAM_MATCH;
  logic [3:0]  TCAM_ADDR_WR, TCAM_MATCH_ADDR;
  logic [31:0] TCAM_DIN, TCAM_DIN_MASK, TCAM_CAM_DIN, TCAM_CAM_DATA_MASK;

  tcam_lookup_client dut (
    .CLK(CLK), .RSTN(RSTN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_KEY(REQ_KEY),
    .REQ_MASK(REQ_MASK), .REQ_TAG(REQ_TAG),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_HIT(RES_HIT),
    .RES_ADDR(RES_ADDR), .RES_TAG(RES_TAG),
    .CFG_WR_REQ(CFG_WR_REQ), .CFG_WR_ADDR(CFG_WR_ADDR), .CFG_WR_DATA(CFG_WR_DATA),
    .CFG_WR_MASK(CFG_WR_MASK), .CFG_WR_ACK(CFG_WR_ACK),
    .TCAM_WR(TCAM_WR), .TCAM_ADDR_WR(TCAM_ADDR_WR), .TCAM_DIN(TCAM_DIN),
    .TCAM_DIN_MASK(TCAM_DIN_MASK), .TCAM_BUSY(TCAM_BUSY),
    .TCAM_CAM_DIN(TCAM_CAM_DIN), .TCAM_CAM_DATA_MASK(TCAM_CAM_DATA_MASK),
    .TCAM_MATCH(TCAM_MATCH), .TCAM_MATCH_ADDR(TCAM_MATCH_ADDR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural TCAM: lowest matching entry wins, miss drives a junk address.
  logic [31:0] tcam_data [16] = '{5: 32'hDEAD_BEEF, default: 32'h0};
  logic        tcam_vld  [16] = '{5: 1'b1, default: 1'b0};
  logic        m_hit = 1'b0;
  logic [3:0]  m_addr = 4'h0;

  function automatic logic [4:0] find(input logic [31:0] key, input logic [31:0] mask);
    for (int i = 0; i < 16; i++)
      if (tcam_vld[i] && (((key ^ tcam_data[i]) & mask) == 32'h0)) return {1'b1, 4'(i)};
    return 5'h0F;
  endfunction

  always @(posedge CLK) begin
    logic [4:0] f;
    if (TCAM_WR) begin
      tcam_data[TCAM_ADDR_WR] <= TCAM_DIN;
      tcam_vld[TCAM_ADDR_WR]  <= 1'b1;
    end
    f = find(TCAM_CAM_DIN, TCAM_CAM_DATA_MASK);
    m_hit  <= f[4];
    m_addr <= f[3:0];
  end
  assign TCAM_MATCH      = m_hit;
  assign TCAM_MATCH_ADDR = m_addr;

  typedef struct packed {logic hit; logic [3:0] addr; logic [7:0] tag;} res_t;
  res_t sb_q[$];
  int   wr_cycles = 0, ack_cnt = 0, acc_wr = 0;

  // Inputs change #1 after posedge, so the negedge sees what the next posedge samples.
  always @(negedge CLK) begin
    if (!RSTN) begin
      sb_q.delete();
    end else begin
      if (REQ_VALID && REQ_READY) begin
        logic [4:0] f;
        f = find(REQ_KEY, REQ_MASK);
        sb_q.push_back('{hit: f[4], addr: f[4] ? f[3:0] : 4'h0, tag: REQ_TAG});
        if (CFG_WR_REQ) acc_wr++;
      end
      if (RES_VALID && RES_READY) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'(RES_TAG), 64'hFFFF);
        end else begin
          res_t e;
          e = sb_q.pop_front();
          chk("sb_result", 64'({RES_HIT, RES_ADDR, RES_TAG}), 64'(e));
        end
      end
      if (TCAM_WR) begin
        wr_cycles++;
        chk("wr_after_drain", 64'(sb_q.size()), 64'(0));
        chk("wr_addr", 64'(TCAM_ADDR_WR), 64'(CFG_WR_ADDR));
        chk("wr_data", 64'(TCAM_DIN), 64'(CFG_WR_DATA));
        chk("wr_mask", 64'(TCAM_DIN_MASK), 64'(CFG_WR_MASK));
      end
      if (CFG_WR_ACK) ack_cnt++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] key, input logic [7:0] tag);
    REQ_VALID = 1'b1;
    REQ_KEY   = key;
    REQ_TAG   = tag;
    for (int n = 0; n < 50; n++) begin
      if (REQ_READY) begin
        tick();
        REQ_VALID = 1'b0;
        return;
      end
      tick();
    end
    chk("send_timeout", 64'(REQ_READY), 64'(1));
    REQ_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    int n;
    RSTN = 1'b0; REQ_VALID = 1'b0; REQ_KEY = '0; REQ_MASK = '1; REQ_TAG = '0;
    RES_READY = 1'b1; CFG_WR_REQ = 1'b0; CFG_WR_ADDR = '0; CFG_WR_DATA = '0;
    CFG_WR_MASK = '0; TCAM_BUSY = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", 64'(REQ_READY), 64'(0));
    chk("rst_res_valid", 64'(RES_VALID), 64'(0));
    chk("rst_res_fields", 64'({RES_HIT, RES_ADDR, RES_TAG}), 64'(0));
    chk("rst_ack", 64'(CFG_WR_ACK), 64'(0));
    chk("rst_tcam_wr", 64'(TCAM_WR), 64'(0));
    chk("rst_cam_din", 64'(TCAM_CAM_DIN), 64'(0));
    chk("rst_cam_mask", 64'(TCAM_CAM_DATA_MASK), 64'(0));
    chk("rst_wr_fields", 64'({TCAM_ADDR_WR, TCAM_DIN}), 64'(0));
    chk("rst_din_mask", 64'(TCAM_DIN_MASK), 64'(0));
    RSTN = 1'b1;
    tick();
    chk("ready_after_rst", 64'(REQ_READY), 64'(1));

    // hit with latency probe, then miss
    send(32'hDEAD_BEEF, 8'h3C);
    chk("hit_lat0", 64'(RES_VALID), 64'(0));
    tick();
    chk("hit_lat1", 64'(RES_VALID), 64'(0));
    tick();
    chk("hit_valid", 64'(RES_VALID), 64'(1));
    chk("hit_res", 64'({RES_HIT, RES_ADDR, RES_TAG}), 64'({1'b1, 4'd5, 8'h3C}));
    tick();
    send(32'h1234_5678, 8'h5A);
    tick(); tick();
    chk("miss_valid", 64'(RES_VALID), 64'(1));
    chk("miss_res", 64'({RES_HIT, RES_ADDR, RES_TAG}), 64'({1'b0, 4'd0, 8'h5A}));
    tick(); tick();

    // backpressure: credit limits acceptance to four
    RES_READY = 1'b0;
    nxt = 0;
    for (int c = 0; c < 6; c++) begin
      REQ_VALID = 1'b1;
      REQ_TAG   = 8'(nxt);
      REQ_KEY   = (nxt == 2) ? 32'hDEAD_BEEF : 32'h1000 + 32'(nxt);
      if (REQ_READY) nxt++;
      tick();
    end
    chk("bp_accepts", 64'(nxt), 64'(4));
    chk("bp_ready_low", 64'(REQ_READY), 64'(0));
    chk("bp_head_valid", 64'(RES_VALID), 64'(1));
    chk("bp_head_tag", 64'(RES_TAG), 64'(0));
    RES_READY = 1'b1;
    for (int c = 0; c < 20 && nxt < 6; c++) begin
      REQ_VALID = 1'b1;
      REQ_TAG   = 8'(nxt);
      REQ_KEY   = 32'h1000 + 32'(nxt);
      if (REQ_READY) nxt++;
      tick();
    end
    REQ_VALID = 1'b0;
    chk("bp_tail_accepts", 64'(nxt), 64'(6));
    repeat (6) tick();
    chk("bp_drained", 64'(sb_q.size()), 64'(0));

    // write with drain; a lookup waits on the write
    wr_cycles = 0; ack_cnt = 0; acc_wr = 0;
    send(32'hDEAD_BEEF, 8'h10);
    send(32'h1234_5678, 8'h11);
    CFG_WR_REQ  = 1'b1;
    CFG_WR_ADDR = 4'd2;
    CFG_WR_DATA = 32'hA5A5_A5A5;
    CFG_WR_MASK = 32'h0000_00FF;
    REQ_VALID   = 1'b1;
    REQ_KEY     = 32'hA5A5_A5A5;
    REQ_TAG     = 8'h20;
    n = 0;
    while (n < 40 && !CFG_WR_ACK) begin
      tick();
      n++;
    end
    chk("wr_ack_seen", 64'(CFG_WR_ACK), 64'(1));
    chk("wr_ack_min_lat", 64'(n >= 4), 64'(1));
    CFG_WR_REQ = 1'b0;
    send(32'hA5A5_A5A5, 8'h20);
    tick(); tick();
    chk("wr_new_valid", 64'(RES_VALID), 64'(1));
    chk("wr_new_hit", 64'({RES_HIT, RES_ADDR, RES_TAG}), 64'({1'b1, 4'd2, 8'h20}));
    tick();
    chk("wr_strobe_cycles", 64'(wr_cycles), 64'(1));
    chk("wr_ack_pulses", 64'(ack_cnt), 64'(1));
    chk("wr_no_accept_pending", 64'(acc_wr), 64'(0));

    // busy stretch
    wr_cycles = 0; ack_cnt = 0;
    CFG_WR_REQ  = 1'b1;
    CFG_WR_ADDR = 4'd7;
    CFG_WR_DATA = 32'h0BAD_F00D;
    CFG_WR_MASK = 32'h0;
    n = 0;
    while (n < 40 && !TCAM_WR) begin
      tick();
      n++;
    end
    chk("busy_wr_seen", 64'(TCAM_WR), 64'(1));
    TCAM_BUSY = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("busy_no_ack", 64'(CFG_WR_ACK), 64'(0));
    end
    TCAM_BUSY = 1'b0;
    tick();
    chk("busy_ack", 64'(CFG_WR_ACK), 64'(1));
    CFG_WR_REQ = 1'b0;
    tick();
    chk("busy_ack_once", 64'(ack_cnt), 64'(1));
    send(32'h0BAD_F00D, 8'h21);
    repeat (4) tick();

    // reset with two in flight and one stored
    RES_READY = 1'b0;
    nxt = 0;
    for (int c = 0; c < 20 && nxt < 3; c++) begin
      REQ_VALID = 1'b1;
      REQ_TAG   = 8'(8'h30 + nxt);
      REQ_KEY   = 32'hDEAD_BEEF;
      if (REQ_READY) nxt++;
      tick();
    end
    REQ_VALID = 1'b0;
    chk("mid_stored", 64'(RES_VALID), 64'(1));
    RSTN = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(RES_VALID), 64'(0));
    chk("mid_rst_ready", 64'(REQ_READY), 64'(0));
    tick();
    RSTN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_rst_no_valid", 64'(RES_VALID), 64'(0));
    end
    nxt = 0;
    for (int c = 0; c < 6; c++) begin
      REQ_VALID = 1'b1;
      REQ_TAG   = 8'(8'h40 + nxt);
      REQ_KEY   = 32'h2000 + 32'(nxt);
      if (REQ_READY) nxt++;
      tick();
    end
    REQ_VALID = 1'b0;
    chk("post_rst_credit", 64'(nxt), 64'(4));
    RES_READY = 1'b1;
    repeat (8) tick();
    chk("final_sb_empty", 64'(sb_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
